change_dispenser: RTL and testbench

//  Pays out change after a vending transaction. Accepts the change amount from the vending datapath, then
//  - emits coins one at a time to the coin hopper.
//  - greedy order over four denominations: 20, 10, 2, 1.
//  - each coin uses a valid/ack handshake.

---
 rtl/vm_pkg.sv | 33 +++
 rtl/coin_picker.sv | 41 ++++
 rtl/change_dispenser.sv | 131 +++++++++++++
 tb/tb_change_dispenser.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine change path.
// Contents: coin denominations, the COIN_SEL encoding (shared with the coin
// adder), the change_dispenser FSM state type, and a helper that maps a
// COIN_SEL code to its face value.
package vm_pkg;

  localparam int unsigned DENOM_1  = 1;
  localparam int unsigned DENOM_2  = 2;
  localparam int unsigned DENOM_10 = 10;
  localparam int unsigned DENOM_20 = 20;

  localparam logic [1:0] SEL_1  = 2'b00;
  localparam logic [1:0] SEL_2  = 2'b01;
  localparam logic [1:0] SEL_10 = 2'b10;
  localparam logic [1:0] SEL_20 = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    ISSUE  = 2'd2,
    FIN    = 2'd3
  } disp_state_e;

  function automatic logic [4:0] coin_value(input logic [1:0] sel);
    case (sel)
      SEL_1:   coin_value = 5'(DENOM_1);
      SEL_2:   coin_value = 5'(DENOM_2);
      SEL_10:  coin_value = 5'(DENOM_10);
      default: coin_value = 5'(DENOM_20);
    endcase
  endfunction

endpackage

// File: rtl/coin_picker.sv
// Greedy coin choice (combinational).
// Picks the largest denomination that does not exceed the amount still owed
// and whose availability bit is set.
// Ports:
//   remain  in  WIDTH  amount still owed
//   avail   in  4      availability mask, bit index = COIN_SEL code
//   found   out 1      a qualifying denomination exists
//   sel     out 2      COIN_SEL code of the chosen denomination
module coin_picker
  import vm_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] remain,
  input  logic [3:0]       avail,
  output logic             found,
  output logic [1:0]       sel
);

  int unsigned amt;

  always_comb begin
    amt   = int'(remain);
    found = 1'b0;
    sel   = SEL_1;
    if (avail[SEL_20] && amt >= DENOM_20) begin
      found = 1'b1;
      sel   = SEL_20;
    end else if (avail[SEL_10] && amt >= DENOM_10) begin
      found = 1'b1;
      sel   = SEL_10;
    end else if (avail[SEL_2] && amt >= DENOM_2) begin
      found = 1'b1;
      sel   = SEL_2;
    end else if (avail[SEL_1] && amt >= DENOM_1) begin
      found = 1'b1;
      sel   = SEL_1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a latched change amount one coin at a time to
// the hopper, largest denomination first (20, 10, 2, 1), each coin through a
// COIN_VALID/COIN_ACK handshake.
// Optional feature macro: CHANGE_INV_EN (per-denomination inventory; adds
// INV_LD and INV_CNT0..3, where INV_CNTn is the count for COIN_SEL code n).
// Ports:
//   CLK, RST           clock (rising edge), synchronous active-low reset
//   START, AMOUNT      payout request (accepted in IDLE only) and amount
//   COIN_ACK           hopper has taken the current coin
//   COIN_VALID, COIN_SEL  coin request and denomination code to hopper
//   BUSY               high from START accept until DONE
//   DONE               one-cycle pulse at end of payout
//   REMAIN             amount still owed (held after DONE until next START)
//   SHORT              exact change impossible, valid with DONE
module change_dispenser
  import vm_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int INV_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] AMOUNT,
  input  logic             COIN_ACK,
`ifdef CHANGE_INV_EN
  input  logic             INV_LD,
  input  logic [INV_W-1:0] INV_CNT0,
  input  logic [INV_W-1:0] INV_CNT1,
  input  logic [INV_W-1:0] INV_CNT2,
  input  logic [INV_W-1:0] INV_CNT3,
`endif
  output logic             COIN_VALID,
  output logic [1:0]       COIN_SEL,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] REMAIN,
  output logic             SHORT
);

  disp_state_e state;
  logic [3:0]  avail;
  logic        pick_found;
  logic [1:0]  pick_sel;

`ifdef CHANGE_INV_EN
  logic [INV_W-1:0] inv_cnt [4];
  logic             short_q;

  always_comb begin
    for (int i = 0; i < 4; i++) avail[i] = (inv_cnt[i] != '0);
  end
  assign SHORT = short_q;
`else
  // Unlimited supply: every denomination is always available.
  assign avail = (INV_W > 0) ? 4'hF : 4'h0;
  assign SHORT = 1'b0;
`endif

  coin_picker #(.WIDTH(WIDTH)) u_picker (
    .remain (REMAIN),
    .avail  (avail),
    .found  (pick_found),
    .sel    (pick_sel)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      COIN_VALID <= 1'b0;
      COIN_SEL   <= SEL_1;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      REMAIN     <= '0;
`ifdef CHANGE_INV_EN
      short_q    <= 1'b0;
      for (int i = 0; i < 4; i++) inv_cnt[i] <= '0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            REMAIN <= AMOUNT;
            BUSY   <= 1'b1;
            state  <= SELECT;
          end
`ifdef CHANGE_INV_EN
          if (INV_LD) begin
            inv_cnt[0] <= INV_CNT0;
            inv_cnt[1] <= INV_CNT1;
            inv_cnt[2] <= INV_CNT2;
            inv_cnt[3] <= INV_CNT3;
          end
`endif
        end
        SELECT: begin
          if (pick_found) begin
            COIN_SEL   <= pick_sel;
            COIN_VALID <= 1'b1;
            state      <= ISSUE;
          end else begin
            state <= FIN;
          end
        end
        ISSUE: begin
          // COIN_VALID is always high here, so ACK outside ISSUE is ignored.
          if (COIN_ACK) begin
            // Picker guarantees the coin value never exceeds REMAIN.
            REMAIN     <= REMAIN - WIDTH'(coin_value(COIN_SEL));
            COIN_VALID <= 1'b0;
            state      <= SELECT;
`ifdef CHANGE_INV_EN
            inv_cnt[COIN_SEL] <= inv_cnt[COIN_SEL] - 1'b1;
`endif
          end
        end
        FIN: begin
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
`ifdef CHANGE_INV_EN
          short_q <= (REMAIN != '0);
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;
  localparam int WIDTH = 7;
  localparam int INV_W = 4;

  logic             CLK;
  logic             RST;
  logic             START;
  logic [WIDTH-1:0] AMOUNT;
  logic             COIN_ACK;
  logic             COIN_VALID;
  logic [1:0]       COIN_SEL;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] REMAIN;
  logic             SHORT;
`ifdef CHANGE_INV_EN
  logic             INV_LD;
  logic [INV_W-1:0] INV_CNT0, INV_CNT1, INV_CNT2, INV_CNT3;
`endif

  int checks = 0;
  int errors = 0;

  change_dispenser #(.WIDTH(WIDTH), .INV_W(INV_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .AMOUNT     (AMOUNT),
    .COIN_ACK   (COIN_ACK),
`ifdef CHANGE_INV_EN
    .INV_LD     (INV_LD),
    .INV_CNT0   (INV_CNT0),
    .INV_CNT1   (INV_CNT1),
    .INV_CNT2   (INV_CNT2),
    .INV_CNT3   (INV_CNT3),
`endif
    .COIN_VALID (COIN_VALID),
    .COIN_SEL   (COIN_SEL),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .REMAIN     (REMAIN),
    .SHORT      (SHORT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [WIDTH-1:0] amount;
    int               delay;     // ACK wait cycles per coin
    bit               restart;   // pulse a second START while busy
    int               ncoins;
    logic [31:0]      sels;      // coin k code at bits [2k+1:2k]
    bit               exp_short;
    logic [WIDTH-1:0] exp_remain;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          ncoins;
    int          cyc;
    bit          done_seen;
    logic [1:0]  sel;
    logic [31:0] sels;
    sels = v.sels;
    @(negedge CLK);
    START  = 1'b1;
    AMOUNT = v.amount;
    @(negedge CLK);
    START  = 1'b0;
    AMOUNT = '0;
    check($sformatf("v%0d busy_after_start", idx), int'(BUSY), 1);
    ncoins    = 0;
    cyc       = 0;
    done_seen = 1'b0;
    while (!done_seen && cyc < 400) begin
      if (DONE) begin
        done_seen = 1'b1;
      end else if (COIN_VALID) begin
        sel = COIN_SEL;
        for (int d = 0; d < v.delay; d++) begin
          if (v.restart && d == 0) begin
            START  = 1'b1;
            AMOUNT = 7'd99;
          end
          @(negedge CLK);
          cyc++;
          START  = 1'b0;
          AMOUNT = '0;
          check($sformatf("v%0d hold_valid", idx), int'(COIN_VALID), 1);
          check($sformatf("v%0d hold_sel", idx), int'(COIN_SEL), int'(sel));
        end
        COIN_ACK = 1'b1;
        @(negedge CLK);
        cyc++;
        COIN_ACK = 1'b0;
        if (ncoins < 16)
          check($sformatf("v%0d coin%0d_sel", idx, ncoins), int'(sel),
                int'(sels[2*ncoins +: 2]));
        ncoins++;
      end else begin
        @(negedge CLK);
        cyc++;
      end
    end
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL v%0d done_timeout: got no DONE expected DONE within 400 cycles", idx);
    end else begin
      check($sformatf("v%0d ncoins", idx), ncoins, v.ncoins);
      check($sformatf("v%0d remain", idx), int'(REMAIN), int'(v.exp_remain));
      check($sformatf("v%0d short", idx), int'(SHORT), int'(v.exp_short));
      check($sformatf("v%0d busy_at_done", idx), int'(BUSY), 0);
      @(negedge CLK);
      check($sformatf("v%0d done_pulse", idx), int'(DONE), 0);
      check($sformatf("v%0d remain_hold", idx), int'(REMAIN), int'(v.exp_remain));
    end
  endtask

  initial begin
    int cyc;
    bit saw_done;

    vecs[0] = '{7'd33,  0, 1'b0, 4,  32'h0000_001B, 1'b0, 7'd0};
    vecs[1] = '{7'd47,  0, 1'b0, 6,  32'h0000_015F, 1'b0, 7'd0};
    vecs[2] = '{7'd12,  3, 1'b1, 2,  32'h0000_0006, 1'b0, 7'd0};
    vecs[3] = '{7'd127, 0, 1'b0, 10, 32'h0001_5FFF, 1'b0, 7'd0};
    vecs[4] = '{7'd1,   0, 1'b0, 1,  32'h0000_0000, 1'b0, 7'd0};
    vecs[5] = '{7'd30,  2, 1'b0, 2,  32'h0000_000B, 1'b0, 7'd0};
    vecs[6] = '{7'd2,   1, 1'b0, 1,  32'h0000_0001, 1'b0, 7'd0};

    RST      = 1'b0;
    START    = 1'b0;
    AMOUNT   = '0;
    COIN_ACK = 1'b0;
`ifdef CHANGE_INV_EN
    INV_LD   = 1'b0;
    INV_CNT0 = '0;
    INV_CNT1 = '0;
    INV_CNT2 = '0;
    INV_CNT3 = '0;
`endif
    repeat (2) @(negedge CLK);
    check("rst coin_valid", int'(COIN_VALID), 0);
    check("rst busy", int'(BUSY), 0);
    check("rst done", int'(DONE), 0);
    check("rst short", int'(SHORT), 0);
    check("rst remain", int'(REMAIN), 0);
    check("rst coin_sel", int'(COIN_SEL), 0);
    RST = 1'b1;

`ifdef CHANGE_INV_EN
    // Plenty of stock so the unlimited-supply vectors still apply.
    @(negedge CLK);
    INV_LD = 1'b1;
    INV_CNT0 = 4'd15; INV_CNT1 = 4'd15; INV_CNT2 = 4'd15; INV_CNT3 = 4'd15;
    @(negedge CLK);
    INV_LD = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      INV_LD = 1'b1;
      @(negedge CLK);
      INV_LD = 1'b0;
      run_vec(vecs[i], i);
    end
`else
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
`endif

    // AMOUNT=0: no coin, DONE exactly two cycles after START is sampled.
    @(negedge CLK);
    START  = 1'b1;
    AMOUNT = '0;
    @(negedge CLK);
    START = 1'b0;
    check("zero c1 valid", int'(COIN_VALID), 0);
    check("zero c1 done", int'(DONE), 0);
    @(negedge CLK);
    check("zero c2 valid", int'(COIN_VALID), 0);
    check("zero c2 done", int'(DONE), 0);
    @(negedge CLK);
    check("zero c3 done", int'(DONE), 1);
    check("zero c3 remain", int'(REMAIN), 0);
    @(negedge CLK);
    check("zero c4 done", int'(DONE), 0);

    // ACK while no coin is offered must not change anything.
    COIN_ACK = 1'b1;
    @(negedge CLK);
    COIN_ACK = 1'b0;
    check("idle ack busy", int'(BUSY), 0);
    check("idle ack valid", int'(COIN_VALID), 0);

    // Reset in the middle of a handshake.
    START  = 1'b1;
    AMOUNT = 7'd12;
    @(negedge CLK);
    START = 1'b0;
    cyc = 0;
    while (!COIN_VALID && cyc < 20) begin
      @(negedge CLK);
      cyc++;
    end
    check("mid reset reached issue", int'(COIN_VALID), 1);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    check("mid reset valid", int'(COIN_VALID), 0);
    check("mid reset busy", int'(BUSY), 0);
    check("mid reset remain", int'(REMAIN), 0);
    check("mid reset done", int'(DONE), 0);
    check("mid reset sel", int'(COIN_SEL), 0);
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (DONE || COIN_VALID) saw_done = 1'b1;
    end
    check("mid reset quiet", int'(saw_done), 0);

`ifdef CHANGE_INV_EN
    // Inventory {20,10,2,1} = {0,2,2,0}, AMOUNT=25 -> 10,10,2,2, SHORT.
    @(negedge CLK);
    INV_LD = 1'b1;
    INV_CNT0 = 4'd0; INV_CNT1 = 4'd2; INV_CNT2 = 4'd2; INV_CNT3 = 4'd0;
    @(negedge CLK);
    INV_LD = 1'b0;
    run_vec('{7'd25, 0, 1'b0, 4, 32'h0000_005A, 1'b1, 7'd1}, 7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500us");
    $fatal(1);
  end

endmodule
